// File: rtl/ahb_params_pkg.sv
// Shared AHB constants, arbiter state type and burst-length helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Beat count of a burst; SINGLE and undefined-length INCR report 1.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      HBURST_SINGLE, HBURST_INCR:   burst_len = 5'd1;
      default:                      burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotate-priority encoder: first requester at or after start wins.
// Latency: purely combinational.
// Backpressure: none; vld low when no request is present.
module ahb_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vld
);

  int pos;

  // Walk the request vector from start, wrapping, and keep the first hit.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    pos = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(start) + i) % N;
      if (!vld && req[pos]) begin
        vld      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos[$clog2(N)-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Round-robin AHB arbiter for the shared SRAM slave; holds fixed bursts and locked sequences, parks on DEFAULT_MASTER.
// Latency: grant registered on the HREADY edge; hmaster/hmastlock follow hgrant one accepted cycle later.
// Backpressure: HREADY=0 freezes every register. Optional quantum pre-emption in ARB via macro ARB_TIMEOUT_EN.
module ahb_sram_arbiter
  import ahb_params_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int QUANTUM        = 16
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_MASTERS-1:0]         hbusreq,
  input  logic [NUM_MASTERS-1:0]         hlock,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HBURST,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
  output logic                           hmastlock,
  output logic [1:0]                     arb_state
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

  arb_state_t             state;
  logic [MW-1:0]          rr_ptr;     // last granted master == current grant owner
  logic [3:0]             beat_cnt;
  logic                   lock_tail;  // hlock dropped, one unlocked address phase in flight

  logic [MW-1:0]          rr_start;
  logic [NUM_MASTERS-1:0] pk_gnt;
  logic [MW-1:0]          pk_idx;
  logic                   pk_vld;
  logic [NUM_MASTERS-1:0] rr_gnt;
  logic [MW-1:0]          rr_idx;

  logic owner_keep, go_lock, go_burst, timeout;
  logic do_arb, do_end, hold_owner, take_rr;

  assign rr_start = (rr_ptr == MW'(NUM_MASTERS - 1)) ? '0 : rr_ptr + 1'b1;

  ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req   (hbusreq),
    .start (rr_start),
    .gnt   (pk_gnt),
    .idx   (pk_idx),
    .vld   (pk_vld)
  );

  // With nobody requesting the bus parks on the default master.
  assign rr_gnt = pk_vld ? pk_gnt : DEF_GNT;
  assign rr_idx = pk_vld ? pk_idx : DEF_IDX;

  assign owner_keep = hbusreq[rr_ptr] && (HTRANS != HTRANS_IDLE);
  assign go_lock    = owner_keep && (HTRANS == HTRANS_NONSEQ) && hlock[rr_ptr];
  assign go_burst   = owner_keep && (HTRANS == HTRANS_NONSEQ) && !hlock[rr_ptr]
                      && (burst_len(HBURST) != 5'd1);

  // IDLE or a fresh NONSEQ inside a burst terminates it early and is arbitrated like ARB.
  assign do_arb = (state == ARB) ||
                  ((state == BURST) && ((HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ)));
  // Last burst beat, or the unlocked tail phase after a lock: rotate on this same edge.
  assign do_end = ((state == BURST) && (HTRANS == HTRANS_SEQ) && (beat_cnt == 4'd1)) ||
                  ((state == LOCKED) && !hlock[rr_ptr] && lock_tail);

  assign hold_owner = do_arb && owner_keep && !timeout;
  assign take_rr    = (do_arb && !hold_owner) || do_end;

`ifdef ARB_TIMEOUT_EN
  localparam int QW = $clog2(QUANTUM + 1);
  logic [QW-1:0] own_cnt;
  logic          others_req;
  logic          grant_chg;

  assign others_req = |(hbusreq & ~hgrant);
  assign grant_chg  = take_rr && (rr_idx != rr_ptr);
  // Burst and lock starts are never pre-empted, even at the quantum.
  assign timeout    = (own_cnt >= QW'(QUANTUM - 1)) && others_req && !go_lock && !go_burst;

  // Owned-cycle counter: clears on a grant change, otherwise counts up and saturates.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      own_cnt <= '0;
    end else if (HREADY) begin
      if (grant_chg) begin
        own_cnt <= '0;
      end else if (own_cnt != QW'(QUANTUM)) begin
        own_cnt <= own_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_quantum;
  assign unused_quantum = (QUANTUM > 0);
  assign timeout        = 1'b0;
`endif

  // Arbitration FSM with registered grant, owner index and lock flag.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ARB;
      hgrant    <= DEF_GNT;
      rr_ptr    <= DEF_IDX;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
      beat_cnt  <= '0;
      lock_tail <= 1'b0;
    end else if (HREADY) begin
      hmaster   <= rr_ptr;
      hmastlock <= hlock[rr_ptr];
      if (take_rr) begin
        hgrant    <= rr_gnt;
        rr_ptr    <= rr_idx;
        state     <= ARB;
        beat_cnt  <= '0;
        lock_tail <= 1'b0;
      end else if (hold_owner) begin
        lock_tail <= 1'b0;
        if (go_lock) begin
          state <= LOCKED;
        end else if (go_burst) begin
          state    <= BURST;
          beat_cnt <= 4'(burst_len(HBURST) - 5'd1);
        end else begin
          state <= ARB;
        end
      end else if (state == BURST) begin
        // BUSY beats hold the counter.
        if (HTRANS == HTRANS_SEQ) beat_cnt <= beat_cnt - 1'b1;
      end else if (state == LOCKED) begin
        lock_tail <= !hlock[rr_ptr];
      end
    end
  end

  assign arb_state = state;

endmodule
